// File: rtl/sccb_responder.sv
// sccb_responder: SCCB/I2C target exposing a 16-bit register pointer and strobe-based register file port.
// Bus inputs are synchronized and edge-decoded; all protocol work happens on decoded SCL edges.
module sccb_responder #(
  parameter logic [6:0] DEV_ADDR    = 7'h36,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        scl,
  input  logic        sda_in,
  output logic        sda_oe,
  output logic [15:0] reg_addr,
  output logic [7:0]  reg_wdata,
  output logic        reg_we,
  output logic        reg_re,
  input  logic [7:0]  reg_rdata,
  output logic        busy
);
  typedef enum logic [3:0] {
    IDLE, DEV, DEV_ACK, AH, AH_ACK, AL, AL_ACK, WR, WR_ACK, RD, RD_ACK, IGNORE
  } state_e;
  state_e                 state_q;
  logic [SYNC_STAGES-1:0] scl_sy_q, sda_sy_q;
  logic                   scl_h_q, sda_h_q, rise_q, fall_q, start_q, stop_q, bit_q;
  logic [6:0]             sr_q;
  logic [2:0]             cnt_q;
  logic                   ph_q, rw_q, load_q;
  logic [7:0]             sh_q;
  logic                   scl_s, sda_s;
  logic [7:0]             byte_w;
  assign scl_s  = scl_sy_q[SYNC_STAGES-1];
  assign sda_s  = sda_sy_q[SYNC_STAGES-1];
  assign byte_w = {sr_q, bit_q};
  // Decoded events are registered so bit_q is the SDA level seen at the detected edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      scl_sy_q <= '1;
      sda_sy_q <= '1;
      scl_h_q  <= 1'b1;
      sda_h_q  <= 1'b1;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      start_q  <= 1'b0;
      stop_q   <= 1'b0;
      bit_q    <= 1'b1;
    end else begin
      scl_sy_q <= {scl_sy_q[SYNC_STAGES-2:0], scl};
      sda_sy_q <= {sda_sy_q[SYNC_STAGES-2:0], sda_in};
      scl_h_q  <= scl_s;
      sda_h_q  <= sda_s;
      rise_q   <= scl_s & ~scl_h_q;
      fall_q   <= ~scl_s & scl_h_q;
      start_q  <= scl_s & scl_h_q & sda_h_q & ~sda_s;
      stop_q   <= scl_s & scl_h_q & ~sda_h_q & sda_s;
      bit_q    <= sda_s;
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      sda_oe    <= 1'b0;
      reg_addr  <= 16'h0000;
      reg_wdata <= 8'h00;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      busy      <= 1'b0;
      sr_q      <= 7'd0;
      cnt_q     <= 3'd0;
      ph_q      <= 1'b0;
      rw_q      <= 1'b0;
      load_q    <= 1'b0;
      sh_q      <= 8'h00;
    end else begin
      reg_we <= 1'b0;
      reg_re <= 1'b0;
      load_q <= 1'b0;
      if (reg_re) sh_q <= reg_rdata;
      // First read byte: the launching fall has passed, so drive its MSB as soon as data lands.
      if (load_q) sda_oe <= ~reg_rdata[7];
      if (start_q) begin
        state_q <= DEV;
        sda_oe  <= 1'b0;
        cnt_q   <= 3'd0;
        ph_q    <= 1'b0;
      end else if (stop_q) begin
        state_q <= IDLE;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
        cnt_q   <= 3'd0;
        ph_q    <= 1'b0;
      end else if (rise_q) begin
        if (state_q inside {DEV, AH, AL, WR}) begin
          sr_q  <= byte_w[6:0];
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            case (state_q)
              DEV: begin
                rw_q    <= bit_q;
                busy    <= byte_w[7:1] == DEV_ADDR;
                state_q <= byte_w[7:1] == DEV_ADDR ? DEV_ACK : IGNORE;
              end
              AH: begin
                reg_addr[15:8] <= byte_w;
                state_q        <= AH_ACK;
              end
              AL: begin
                reg_addr[7:0] <= byte_w;
                state_q       <= AL_ACK;
              end
              default: begin
                reg_wdata <= byte_w;
                reg_we    <= 1'b1;
                state_q   <= WR_ACK;
              end
            endcase
          end
        end else if (state_q == RD) begin
          cnt_q   <= cnt_q + 3'd1;
          state_q <= cnt_q == 3'd7 ? RD_ACK : RD;
        end else if (state_q == RD_ACK) begin
          if (bit_q) state_q <= IGNORE;
          else begin
            reg_addr <= reg_addr + 16'd1;
            reg_re   <= 1'b1;
            state_q  <= RD;
          end
        end else if (state_q inside {DEV_ACK, AH_ACK, AL_ACK, WR_ACK}) ph_q <= 1'b1;
      end else if (fall_q) begin
        if (state_q inside {DEV_ACK, AH_ACK, AL_ACK, WR_ACK}) begin
          if (!ph_q) sda_oe <= 1'b1;
          else begin
            sda_oe  <= 1'b0;
            ph_q    <= 1'b0;
            cnt_q   <= 3'd0;
            state_q <= state_q == DEV_ACK ? (rw_q ? RD : AH) : state_q == AH_ACK ? AL : WR;
            if (state_q == WR_ACK) reg_addr <= reg_addr + 16'd1;
            if (state_q == DEV_ACK && rw_q) begin
              reg_re <= 1'b1;
              load_q <= 1'b1;
            end
          end
        end else if (state_q == RD) sda_oe <= ~sh_q[~cnt_q];
        else sda_oe <= 1'b0;
      end
    end
  end
endmodule
